// File: rtl/fp_unit_arbiter_if.sv
// Bundle of requester, operator and response signals around the shared FP unit arbiter.
// The slave modport is the arbiter's view; the master modport drives requests and unit results.
interface fp_unit_arbiter_if #(
    parameter int unsigned NX    = 8,
    parameter int unsigned NM    = 23,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned OPW   = 2,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned N  = NX + NM + 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Requester side, lane i at [i*N +: N] / [i*OPW +: OPW]
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*N-1:0]   req_a;
    logic [NREQ*N-1:0]   req_b;
    logic [NREQ*OPW-1:0] req_op;

    logic                unit_valid;
    logic [N-1:0]        unit_a;
    logic [N-1:0]        unit_b;
    logic [OPW-1:0]      unit_op;
    logic                unit_res_valid;
    logic [N-1:0]        unit_res;

    logic [NREQ-1:0]     rsp_valid;
    logic [N-1:0]        rsp_data;

    logic [CW-1:0]       outstanding;
    logic                idle;
    logic                err;

    modport slave (
        input  req_valid, req_a, req_b, req_op, unit_res_valid, unit_res,
        output req_ready, unit_valid, unit_a, unit_b, unit_op,
               rsp_valid, rsp_data, outstanding, idle, err
    );

    modport master (
        output req_valid, req_a, req_b, req_op, unit_res_valid, unit_res,
        input  req_ready, unit_valid, unit_a, unit_b, unit_op,
               rsp_valid, rsp_data, outstanding, idle, err
    );
endinterface

// File: rtl/fp_unit_arbiter.sv
// Round-robin sharing of one in-order pipelined FP operator among NREQ requesters.
// An owner FIFO records who issued each op so in-order results route back to their owner.
module fp_unit_arbiter #(
    parameter int unsigned NX    = 8,
    parameter int unsigned NM    = 23,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned OPW   = 2,
    parameter int unsigned DEPTH = 8
) (
    input logic            clk,
    input logic            rst_n,
    fp_unit_arbiter_if.slave bus
);
    localparam int unsigned N  = NX + NM + 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned IW = $clog2(NREQ);

    // ---------------------------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------------------------
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [IW-1:0]   owner_mem [DEPTH];

    logic            unit_valid_q;
    logic [N-1:0]    unit_a_q, unit_b_q;
    logic [OPW-1:0]  unit_op_q;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [N-1:0]    rsp_data_q;
    logic            err_q;

    // ---------------------------------------------------------------------------------------
    // Grant
    // ---------------------------------------------------------------------------------------
    logic            found;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   cand;
    int unsigned     scan_idx;
    logic [NREQ-1:0] grant_vec;
    logic            not_full;
    logic            accept;
    logic            pop;
    logic            spurious;

    always_comb begin
        found    = 1'b0;
        winner   = '0;
        cand     = '0;
        scan_idx = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = 32'(rr_ptr_q) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            cand = IW'(scan_idx);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // No pop bypass: a full FIFO blocks accepts even when a result drains this cycle.
    assign not_full = (count_q < CW'(DEPTH));
    assign accept   = found & not_full;
    assign pop      = bus.unit_res_valid & (count_q != '0);
    assign spurious = bus.unit_res_valid & (count_q == '0);

    always_comb begin
        grant_vec = '0;
        if (accept) begin
            grant_vec[winner] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);
        end
    end

    always_comb begin
        count_d = count_q + CW'(accept) - CW'(pop);
    end

    always_comb begin
        rsp_valid_d = '0;
        if (pop) begin
            rsp_valid_d[owner_mem[rd_ptr_q]] = 1'b1;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Owner FIFO
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (accept) begin
            owner_mem[wr_ptr_q] <= winner;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Issue and response registers
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unit_valid_q <= 1'b0;
            unit_a_q     <= '0;
            unit_b_q     <= '0;
            unit_op_q    <= '0;
        end else begin
            unit_valid_q <= accept;
            if (accept) begin
                unit_a_q  <= bus.req_a[winner*N +: N];
                unit_b_q  <= bus.req_b[winner*N +: N];
                unit_op_q <= bus.req_op[winner*OPW +: OPW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            if (pop) begin
                rsp_data_q <= bus.unit_res;
            end
            if (spurious) begin
                err_q <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------------------------
    always_comb begin
        bus.req_ready   = grant_vec;
        bus.unit_valid  = unit_valid_q;
        bus.unit_a      = unit_a_q;
        bus.unit_b      = unit_b_q;
        bus.unit_op     = unit_op_q;
        bus.rsp_valid   = rsp_valid_q;
        bus.rsp_data    = rsp_data_q;
        bus.outstanding = count_q;
        bus.idle        = (count_q == '0) & ~unit_valid_q;
        bus.err         = err_q;
    end
endmodule
